// File: rtl/fetch_unit_if.sv
// Fetch-to-memory and fetch-to-decoder signal bundle; combinational wiring only.
// The master side is driven by the fetch unit; stall applies backpressure from the decoder.
interface fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [15:0]       mem_rdata;
    logic              stall;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_target;
    logic [15:0]       instr_out;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output mem_addr, mem_rd_en, instr_out, instr_valid, pc_out,
        input  mem_rdata, stall, branch_en, branch_target
    );

    modport slave (
        input  mem_addr, mem_rd_en, instr_out, instr_valid, pc_out,
        output mem_rdata, stall, branch_en, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, 1-cycle memory reads, output register plus one-entry skid buffer.
// Latency 2 cycles issue-to-instr_valid; stall holds the output and reads stop once nothing could land.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       PC_INC   = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_unit_if.master  bus
);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
    logic              inflight_q,    inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              skid_valid_q,  skid_valid_d;
    logic [15:0]       skid_instr_q,  skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q,     skid_pc_d;
    logic [15:0]       instr_out_q,   instr_out_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] pc_out_q,      pc_out_d;

    logic issue;
    logic advance;

    // A read is only issued when its data is guaranteed a landing slot next cycle.
    assign issue   = reset_n & ~bus.branch_en & ~skid_valid_q
                   & ~(bus.stall & instr_valid_q & inflight_q);
    assign advance = ~bus.stall | ~instr_valid_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        instr_out_d   = instr_out_q;
        instr_valid_d = instr_valid_q;
        pc_out_d      = pc_out_q;

        if (bus.branch_en) begin
            // Data returning this cycle belongs to the wrong path and is dropped.
            fetch_pc_d    = bus.branch_target;
            inflight_d    = 1'b0;
            skid_valid_d  = 1'b0;
            instr_valid_d = 1'b0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + PC_STEP;
            end

            if (advance) begin
                if (skid_valid_q) begin
                    instr_out_d   = skid_instr_q;
                    pc_out_d      = skid_pc_q;
                    instr_valid_d = 1'b1;
                    skid_valid_d  = inflight_q;
                    if (inflight_q) begin
                        skid_instr_d = bus.mem_rdata;
                        skid_pc_d    = inflight_pc_q;
                    end
                end else if (inflight_q) begin
                    instr_out_d   = bus.mem_rdata;
                    pc_out_d      = inflight_pc_q;
                    instr_valid_d = 1'b1;
                end else begin
                    instr_valid_d = 1'b0;
                end
            end else if (inflight_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = bus.mem_rdata;
                skid_pc_d    = inflight_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            instr_out_q   <= '0;
            instr_valid_q <= 1'b0;
            pc_out_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            pc_out_q      <= pc_out_d;
        end
    end

    assign bus.mem_addr    = fetch_pc_q;
    assign bus.mem_rd_en   = issue;
    assign bus.instr_out   = instr_out_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc_out      = pc_out_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: the accepted instruction stream must equal the sequential program
// restarted at every redirect, with fixed redirect latency, stall hold and reset behaviour.
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    fetch_unit_if #(.ADDR_W(16)) bus0 ();
    fetch_unit_if #(.ADDR_W(16)) bus1 ();

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .PC_INC(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFE), .PC_INC(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    function automatic logic [15:0] word(input logic [15:0] a);
        return 16'h5000 + a;
    endfunction

    // Synchronous instruction memories, one-cycle read latency.
    always @(posedge clk) begin
        if (bus0.mem_rd_en === 1'b1) bus0.mem_rdata <= word(bus0.mem_addr);
        if (bus1.mem_rd_en === 1'b1) bus1.mem_rdata <= word(bus1.mem_addr);
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard of program-order PCs expected to be accepted by the decoder.
    logic [15:0] expq[$];
    logic [15:0] next_push;

    task automatic step(input logic rst, input logic st, input logic br, input logic [15:0] tgt);
        @(posedge clk);
        #1;
        if (reset_n !== 1'b1) begin
            expq.delete();
            next_push = 16'h0000;
        end else if (bus0.branch_en === 1'b1) begin
            expq.delete();
            next_push = bus0.branch_target;
        end
        while (expq.size() < 8) begin
            expq.push_back(next_push);
            next_push = next_push + 16'd1;
        end
        reset_n            = rst;
        bus0.stall         = st;
        bus0.branch_en     = br;
        bus0.branch_target = tgt;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    logic        prev_rst_low = 1'b0;
    logic        prev_v = 1'b0, prev_st = 1'b0;
    logic [15:0] prev_pc = '0, prev_ins = '0;
    int          d  = 0;
    int          d1 = 0;
    logic [15:0] redir_pc = '0;
    logic [2:0]  st_hist = '0;
    logic [15:0] exp1 = 16'hFFFE;

    initial begin
        forever begin
            logic        rst, st, br, v, rd, v1;
            logic [15:0] pc, ins, addr, tgt, e;
            @(negedge clk);
            rst = reset_n; st = bus0.stall; br = bus0.branch_en; tgt = bus0.branch_target;
            v = bus0.instr_valid; pc = bus0.pc_out; ins = bus0.instr_out;
            rd = bus0.mem_rd_en; addr = bus0.mem_addr; v1 = bus1.instr_valid;

            if (prev_rst_low) begin
                chk("reset_valid", {31'd0, v}, 32'd0);
                chk("reset_instr", {16'd0, ins}, 32'd0);
                chk("reset_pc", {16'd0, pc}, 32'd0);
            end
            if (rst !== 1'b1 || br === 1'b1)
                chk("rd_en_redirect", {31'd0, rd}, 32'd0);
            else if (d == 1) begin
                chk("restart_rd_en", {31'd0, rd}, 32'd1);
                chk("restart_addr", {16'd0, addr}, {16'd0, redir_pc});
            end
            if (d == 1 || d == 2)
                chk("redirect_bubble", {31'd0, v}, 32'd0);
            if (d >= 3 && st_hist == 3'b000)
                chk("stream_valid", {31'd0, v}, 32'd1);
            if (d >= 2 && prev_v && prev_st) begin
                chk("hold_valid", {31'd0, v}, 32'd1);
                chk("hold_pc", {16'd0, pc}, {16'd0, prev_pc});
                chk("hold_instr", {16'd0, ins}, {16'd0, prev_ins});
            end
            if (v === 1'b1 && st === 1'b0) begin
                if (expq.size() == 0) begin
                    chk("accept_unexpected", {16'd0, pc}, 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk("accept_pc", {16'd0, pc}, {16'd0, e});
                    chk("accept_instr", {16'd0, ins}, {16'd0, word(e)});
                end
            end

            if (d1 >= 3) chk("wrap_valid", {31'd0, v1}, 32'd1);
            if (v1 === 1'b1 && d1 >= 1) begin
                chk("wrap_pc", {16'd0, bus1.pc_out}, {16'd0, exp1});
                chk("wrap_instr", {16'd0, bus1.instr_out}, {16'd0, word(exp1)});
                exp1 = exp1 + 16'd1;
            end

            if (rst !== 1'b1) begin
                d = 1; d1 = 1; redir_pc = 16'h0000; exp1 = 16'hFFFE;
            end else begin
                if (br === 1'b1) begin
                    d = 1; redir_pc = tgt;
                end else if (d != 0 && d < 100) d++;
                if (d1 != 0 && d1 < 100) d1++;
            end
            prev_rst_low = (rst !== 1'b1);
            prev_v = v; prev_st = st; prev_pc = pc; prev_ins = ins;
            st_hist = {st_hist[1:0], st};
        end
    end

    initial begin
        reset_n = 1'b0;
        bus0.stall = 1'b0; bus0.branch_en = 1'b0; bus0.branch_target = '0;
        bus1.stall = 1'b0; bus1.branch_en = 1'b0; bus1.branch_target = '0;
        next_push = 16'h0000;

        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b1, 16'h0040);
        repeat (6) step(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b1, 16'h0100);
        repeat (2) step(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b1, 16'hFFFD);
        repeat (6) step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b1, 16'h0200);
        step(1'b1, 1'b0, 1'b1, 16'h0300);
        repeat (6) step(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (4) step(1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (2) step(1'b1, 1'b1, 1'b0, 16'h0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_st, r_br;
            logic [15:0] r_tgt;
            r_rst = ($urandom_range(99) != 0);
            r_st  = ($urandom_range(99) < 35);
            r_br  = ($urandom_range(15) == 0);
            r_tgt = ($urandom_range(3) == 0) ? 16'hFFFC + 16'($urandom_range(3))
                                             : 16'($urandom);
            step(r_rst, r_st, r_br, r_tgt);
        end

        repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction decoder and drives its 16-bit instruction input.
- Holds the program counter and issues word reads to a synchronous instruction memory (1-cycle read latency).
- Presents fetched instructions to the decoder with a valid/stall handshake, using a one-entry skid buffer so no fetched word is lost.
- Accepts branch/jump redirects from the execute stage.

Parameters:
ADDR_W, 16, width of PC and memory address
RESET_PC, 16'h0000, first fetch address after reset
PC_INC, 1, PC increment per instruction (word-addressed memory)

Ports:
clk  input  1  single system clock, rising edge
reset_n  input  1  synchronous, active-low reset
mem_addr  output  ADDR_W  instruction memory read address (= fetch_pc)
mem_rd_en  output  1  read strobe; mem_rdata valid the cycle after
mem_rdata  input  16  instruction word from memory
stall  input  1  downstream cannot accept instr_out this cycle
branch_en  input  1  redirect request, one-cycle pulse
branch_target  input  ADDR_W  redirect address
instr_out  output  16  instruction to the decoder
instr_valid  output  1  instr_out holds a real instruction
pc_out  output  ADDR_W  address of instr_out

Behaviour:
- Synchronous, active-low reset (sampled on clk rising edge while reset_n=0):
  - fetch_pc <= RESET_PC
  - instr_out <= 16'h0000, instr_valid <= 0, pc_out <= 0
  - skid buffer empty, inflight <= 0
  - mem_rd_en = 0 while reset_n=0
- Reset has priority over branch_en and stall.
- Internal state:
  - fetch_pc
  - inflight: read issued last cycle
  - inflight_pc
  - skid_valid / skid_instr / skid_pc
  - output register: instr_out / instr_valid / pc_out
- Issue rule: mem_rd_en = reset_n & !branch_en & !skid_valid & !(stall & instr_valid & inflight).
  - On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + PC_INC.
  - fetch_pc is modulo 2^ADDR_W: 16'hFFFF wraps to 16'h0000.
- Latency: read issued in cycle N appears on instr_out with instr_valid=1 in cycle N+2. Throughput is 1 instruction/cycle when stall=0.
- Output register advance (when stall=0 or instr_valid=0):
  - If skid_valid: load from skid, clear skid.
  - Else if inflight: load mem_rdata / inflight_pc.
  - Else: instr_valid <= 0. instr_out and pc_out hold their previous values.
- Hold (stall=1 and instr_valid=1): instr_out, pc_out and instr_valid are unchanged. If inflight, mem_rdata/inflight_pc go into the skid buffer.
- Capacity: one output register + one skid entry + at most one read in flight.
  - No read may be issued whose data would have nowhere to land.
  - No instruction is dropped or duplicated.
- Branch (branch_en=1 in cycle T, stall ignored):
  - In T: mem_rd_en=0.
  - End of T: fetch_pc <= branch_target, instr_valid <= 0, skid cleared. Data returning in T (read issued T-1) is discarded.
  - T+1: read of branch_target issued.
  - T+3: target instruction valid with pc_out = branch_target.
  - instr_valid is low in T+1 and T+2: a fixed 2-bubble penalty.
- Branch during a full skid or during stall: everything is cleared; the branch wins.
- A back-to-back branch in T+1 overrides the earlier target. The last branch wins.
- stall with instr_valid=0: the output register may fill (bubble collapse).

Test Plan:
1. Memory word at addr i = 16'h5000+i, RESET_PC=0, release reset at cycle 0, stall=0 -> mem_addr 0,1,2,… from cycle 0; instr_out 5000/5001/5002 with pc_out 0/1/2 in cycles 2/3/4, no gaps.
2. Steady stream, stall=1 for cycles 5–7 -> instr_out/pc_out frozen at 5003/3; exactly one further read completes into the skid buffer, then mem_rd_en=0; after release the sequence continues 5004, 5005… with no drop or duplicate.
3. branch_en pulse at cycle 6 with branch_target=16'h0040 -> mem_rd_en=0 in cycle 6, mem_addr=0040 in cycle 7, instr_valid=0 in cycles 7–8, instr_out=5040/pc_out=0040 in cycle 9, then 5041…
4. Skid buffer full and stall=1, branch_en to 16'h0100 -> skid and output cleared; instr 5100 appears 3 cycles later regardless of stall level once stall drops; the stale skid word is never presented.
5. RESET_PC=16'hFFFE -> pc_out sequence FFFE, FFFF, 0000, 0001 with matching data.
6. reset_n low for one cycle mid-stream, while stalled with the skid full -> next cycle instr_valid=0 and mem_rd_en=0; fetch restarts at RESET_PC; first instruction appears 2 cycles after reset_n returns high.
